// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: 32-bit binary to 8-digit packed BCD, iterative double-dabble.
// One bit per cycle: start captured in IDLE, done pulses 32 edges later.
// Ports: clk, rst (sync, active-high), start, bin[31:0] in;
//        busy, done, bcd[31:0], overflow, sign out.
// Option: define BIN2BCD_CONV_SIGNED_EN to treat bin as two's complement
//         (sign reports the operand's sign; otherwise sign is tied 0).
module bin2bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow,
    output logic        sign
);

    typedef enum logic {IDLE, CONV} state_t;

    localparam logic [31:0] MAX_MAG = 32'd100000000;
    localparam logic [31:0] SAT_BCD = 32'h99999999;

    state_t      state, state_nx;
    logic [31:0] opr, opr_nx;
    logic [31:0] scr, scr_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        ovf_cap, ovf_cap_nx;
    logic        done_nx;
    logic [31:0] bcd_nx;
    logic        ovf_nx;
    logic [31:0] mag;
    logic [31:0] adj;
    logic [63:0] sh;

`ifdef BIN2BCD_CONV_SIGNED_EN
    logic sign_cap, sign_cap_nx;
    logic sign_q, sign_nx;

    // -2^31 negates to itself, i.e. magnitude 2^31, which overflows
    assign mag  = bin[31] ? (~bin + 32'd1) : bin;
    assign sign = sign_q;
`else
    assign mag  = bin;
    assign sign = 1'b0;
`endif

    assign busy = (state == CONV);

    // Add-3 correction keeps every digit <= 9 after the shift
    always_comb begin
        adj = scr;
        for (int i = 0; i < 8; i++) begin
            if (scr[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
        end
    end

    assign sh = {adj, opr} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opr      <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_cap  <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
`ifdef BIN2BCD_CONV_SIGNED_EN
            sign_cap <= 1'b0;
            sign_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            opr      <= opr_nx;
            scr      <= scr_nx;
            cnt      <= cnt_nx;
            ovf_cap  <= ovf_cap_nx;
            done     <= done_nx;
            bcd      <= bcd_nx;
            overflow <= ovf_nx;
`ifdef BIN2BCD_CONV_SIGNED_EN
            sign_cap <= sign_cap_nx;
            sign_q   <= sign_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        opr_nx     = opr;
        scr_nx     = scr;
        cnt_nx     = cnt;
        ovf_cap_nx = ovf_cap;
        done_nx    = 1'b0;
        bcd_nx     = bcd;
        ovf_nx     = overflow;
`ifdef BIN2BCD_CONV_SIGNED_EN
        sign_cap_nx = sign_cap;
        sign_nx     = sign_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    opr_nx     = mag;
                    scr_nx     = '0;
                    cnt_nx     = '0;
                    ovf_cap_nx = (mag >= MAX_MAG);
`ifdef BIN2BCD_CONV_SIGNED_EN
                    sign_cap_nx = bin[31];
`endif
                    state_nx   = CONV;
                end
            end
            CONV: begin
                scr_nx = sh[63:32];
                opr_nx = sh[31:0];
                cnt_nx = cnt + 5'd1;
                // Outputs only change here, so scratch never leaks out
                if (cnt == 5'd31) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    bcd_nx   = ovf_cap ? SAT_BCD : sh[63:32];
                    ovf_nx   = ovf_cap;
`ifdef BIN2BCD_CONV_SIGNED_EN
                    sign_nx  = sign_cap;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
